// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the encoder -> channel -> Viterbi decoder slice.
package viterbi_pkg;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    BURST,
    DONE
  } sched_state_t;

  // Number of set bits in a 2-bit symbol (bits flipped by a mask).
  function automatic logic [1:0] popcount2(input sym_t s);
    return {1'b0, s[0]} + {1'b0, s[1]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and variable increment.
// A clear in the same cycle as an increment loads the increment, so a
// symbol arriving with start_i is counted from zero.
module sat_counter #(
  parameter int unsigned W     = 32,
  parameter int unsigned INC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [W-1:0]     cnt_o
);

  localparam int unsigned SW = W + 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  // Next count: clear-and-load, or add with saturation at all-ones.
  always_comb begin
    sum = {1'b0, cnt_q} + SW'(inc_i);
    if (clr_i) begin
      cnt_d = W'(inc_i);
    end else if (sum[W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[W-1:0];
    end
  end

  // Counter register, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/channel_error_scheduler.sv
// Channel stage between convolutional encoder and Viterbi decoder: registered
// symbol pass-through with a gap/burst error-injection schedule and statistics.
module channel_error_scheduler
  import viterbi_pkg::*;
#(
  parameter int unsigned GAP_W   = 16,
  parameter int unsigned BURST_W = 8,
  parameter int unsigned NB_W    = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [GAP_W-1:0]   cfg_gap_i,
  input  logic [BURST_W-1:0] cfg_burst_len_i,
  input  logic [1:0]         cfg_mask_i,
  input  logic [NB_W-1:0]    cfg_num_bursts_i,
  input  logic [1:0]         sym_i,
  input  logic               sym_valid_i,
  output logic [1:0]         sym_o,
  output logic               sym_valid_o,
  output logic               inj_active_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   sym_ct_o,
  output logic [CNT_W-1:0]   bit_err_ct_o
);

  localparam int unsigned PH_W = (GAP_W > BURST_W) ? GAP_W : BURST_W;

  sched_state_t       state_q, state_d, eff_state;
  logic [GAP_W-1:0]   gap_q, eff_gap;
  logic [BURST_W-1:0] len_q, eff_len;
  sym_t               mask_q, eff_mask;
  logic [NB_W-1:0]    nb_q, eff_nb;
  logic [PH_W-1:0]    phase_q, phase_d, eff_phase, gap_last, len_last;
  logic [NB_W-1:0]    bcnt_q, bcnt_d, eff_bcnt, bcnt_inc;
  logic               start_go, inj, run;
  sym_t               sym_q;
  logic               sym_valid_q, inj_q, busy_q, done_q;
  logic [1:0]         err_inc;

  // Schedule decode. The symbol in a start_i cycle already belongs to the new
  // schedule, so the cycle is evaluated in an "effective" state/config that
  // folds the start (or abort) in before the usual gap/burst stepping.
  always_comb begin
    start_go  = start_i && !abort_i && (state_q == IDLE || state_q == DONE);
    eff_gap   = start_go ? cfg_gap_i        : gap_q;
    eff_len   = start_go ? cfg_burst_len_i  : len_q;
    eff_mask  = start_go ? cfg_mask_i       : mask_q;
    eff_nb    = start_go ? cfg_num_bursts_i : nb_q;
    if (abort_i) begin
      eff_state = IDLE;
      eff_phase = '0;
      eff_bcnt  = bcnt_q;
    end else if (start_go) begin
      eff_state = (cfg_gap_i == '0 && cfg_burst_len_i != '0) ? BURST : GAP;
      eff_phase = '0;
      eff_bcnt  = '0;
    end else begin
      eff_state = state_q;
      eff_phase = phase_q;
      eff_bcnt  = bcnt_q;
    end
    gap_last = PH_W'(eff_gap) - PH_W'(1);
    len_last = PH_W'(eff_len) - PH_W'(1);
    bcnt_inc = eff_bcnt + NB_W'(1);
    inj      = sym_valid_i && (eff_state == BURST);
    run      = (eff_state == GAP) || (eff_state == BURST);
    err_inc  = inj ? popcount2(eff_mask) : 2'b00;
    state_d  = eff_state;
    phase_d  = eff_phase;
    bcnt_d   = eff_bcnt;
    if (sym_valid_i) begin
      case (eff_state)
        GAP: begin
          // G==0 only lands here when L==0 too: no gap ever completes.
          if (eff_gap != '0 && eff_phase == gap_last) begin
            phase_d = '0;
            if (eff_len == '0) begin
              bcnt_d = bcnt_inc;
              if (eff_nb != '0 && bcnt_inc == eff_nb) state_d = DONE;
            end else begin
              state_d = BURST;
            end
          end else begin
            phase_d = eff_phase + PH_W'(1);
          end
        end
        BURST: begin
          if (eff_phase == len_last) begin
            phase_d = '0;
            bcnt_d  = bcnt_inc;
            if (eff_nb != '0 && bcnt_inc == eff_nb) state_d = DONE;
            else if (eff_gap != '0)                  state_d = GAP;
            else                                     state_d = BURST;
          end else begin
            phase_d = eff_phase + PH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Schedule FSM, latched config and registered channel outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bcnt_q      <= '0;
      gap_q       <= '0;
      len_q       <= '0;
      mask_q      <= '0;
      nb_q        <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      inj_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bcnt_q      <= bcnt_d;
      if (start_go) begin
        gap_q  <= cfg_gap_i;
        len_q  <= cfg_burst_len_i;
        mask_q <= cfg_mask_i;
        nb_q   <= cfg_num_bursts_i;
      end
      sym_q       <= sym_i ^ (inj ? eff_mask : 2'b00);
      sym_valid_q <= sym_valid_i;
      inj_q       <= inj;
      busy_q      <= run;
      done_q      <= (eff_state == DONE);
    end
  end

  sat_counter #(.W(CNT_W), .INC_W(1)) u_sym_ct (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_go),
    .inc_i (sym_valid_i && run),
    .cnt_o (sym_ct_o)
  );

  sat_counter #(.W(CNT_W), .INC_W(2)) u_bit_err_ct (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_go),
    .inc_i (err_inc),
    .cnt_o (bit_err_ct_o)
  );

  assign sym_o        = sym_q;
  assign sym_valid_o  = sym_valid_q;
  assign inj_active_o = inj_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_channel_error_scheduler.sv
// Bench for channel_error_scheduler: index-based schedule model checked every
// cycle, plus literal end-of-scenario expectations.
module tb_channel_error_scheduler;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [15:0]      cfg_gap_i = '0;
  logic [7:0]       cfg_burst_len_i = '0;
  logic [1:0]       cfg_mask_i = '0;
  logic [7:0]       cfg_num_bursts_i = '0;
  logic [1:0]       sym_i = '0;
  logic             sym_valid_i = 1'b0;
  logic [1:0]       sym_o;
  logic             sym_valid_o, inj_active_o, busy_o, done_o;
  logic [CNT_W-1:0] sym_ct_o, bit_err_ct_o;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  channel_error_scheduler #(
    .GAP_W(16), .BURST_W(8), .NB_W(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .cfg_gap_i(cfg_gap_i), .cfg_burst_len_i(cfg_burst_len_i),
    .cfg_mask_i(cfg_mask_i), .cfg_num_bursts_i(cfg_num_bursts_i),
    .sym_i(sym_i), .sym_valid_i(sym_valid_i),
    .sym_o(sym_o), .sym_valid_o(sym_valid_o), .inj_active_o(inj_active_o),
    .busy_o(busy_o), .done_o(done_o), .sym_ct_o(sym_ct_o), .bit_err_ct_o(bit_err_ct_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Model: a run numbers its valid symbols 0,1,2...; symbol i is corrupted
  // when (i mod (G+L)) >= G within the first N periods; the run ends once
  // N*(G+L) symbols have been seen.
  int         m_g, m_l, m_n, m_idx, m_span, m_ct, m_err;
  logic [1:0] m_m;
  bit         m_active, m_done, m_corrupt;
  logic [1:0] e_sym = '0;
  bit         e_valid = 0, e_inj = 0, e_busy = 0, e_done = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_g = 0; m_l = 0; m_n = 0; m_m = '0; m_idx = 0; m_ct = 0; m_err = 0;
      m_active = 0; m_done = 0;
      e_sym = '0; e_valid = 0; e_inj = 0; e_busy = 0; e_done = 0;
    end else begin
      m_corrupt = 0;
      if (abort_i) begin
        m_active = 0; m_done = 0; e_busy = 0; e_done = 0;
      end else begin
        if (start_i && !m_active) begin
          m_g = int'(cfg_gap_i); m_l = int'(cfg_burst_len_i);
          m_n = int'(cfg_num_bursts_i); m_m = cfg_mask_i;
          m_idx = 0; m_ct = 0; m_err = 0; m_active = 1; m_done = 0;
        end
        e_busy = m_active;
        e_done = m_done;
        if (m_active && sym_valid_i) begin
          m_span = m_g + m_l;
          if (m_l != 0 && m_span != 0 && (m_idx % m_span) >= m_g &&
              (m_n == 0 || (m_idx / m_span) < m_n))
            m_corrupt = 1;
          m_ct = (m_ct >= CNT_MAX) ? CNT_MAX : m_ct + 1;
          if (m_corrupt) begin
            m_err = m_err + int'(m_m[0]) + int'(m_m[1]);
            if (m_err > CNT_MAX) m_err = CNT_MAX;
          end
          m_idx++;
          if (m_n != 0 && m_span != 0 && m_idx == m_n * m_span) begin
            m_active = 0; m_done = 1;
          end
        end
      end
      e_inj   = m_corrupt;
      e_valid = sym_valid_i;
      e_sym   = sym_i ^ (m_corrupt ? m_m : 2'b00);
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sym_o",        sym_o,        e_sym);
      chk("sym_valid_o",  sym_valid_o,  e_valid);
      chk("inj_active_o", inj_active_o, e_inj);
      chk("busy_o",       busy_o,       e_busy);
      chk("done_o",       done_o,       e_done);
      chk("sym_ct_o",     sym_ct_o,     m_ct);
      chk("bit_err_ct_o", bit_err_ct_o, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic send(input bit v);
    sym_valid_i = v;
    sym_i = 2'($urandom_range(0, 3));
    tick();
  endtask

  task automatic set_cfg(input int g, input int l, input logic [1:0] m, input int n);
    cfg_gap_i = 16'(g); cfg_burst_len_i = 8'(l); cfg_mask_i = m; cfg_num_bursts_i = 8'(n);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 cmp_en = 1'b1;
    chk("reset_sym_ct", sym_ct_o, 0);
    chk("reset_busy", busy_o, 0);
    repeat (2) send(1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) send(1);

    // 1: long gap, single 9-symbol burst, inverting mask; count saturates
    set_cfg(247, 9, 2'b11, 1); start_i = 1'b1;
    repeat (300) send(1);
    repeat (2) send(0);
    chk("t1_bit_err", bit_err_ct_o, 18);
    chk("t1_sym_ct_sat", sym_ct_o, 255);
    chk("t1_done", done_o, 1);
    chk("t1_busy", busy_o, 0);

    // 2: three short bursts, bit0 only; restart directly from DONE
    set_cfg(4, 2, 2'b01, 3); start_i = 1'b1;
    repeat (20) send(1);
    repeat (2) send(0);
    chk("t2_bit_err", bit_err_ct_o, 6);
    chk("t2_sym_ct", sym_ct_o, 18);
    chk("t2_done", done_o, 1);

    // 3: idle cycles interleaved; only the 3rd valid symbol is corrupted
    set_cfg(2, 1, 2'b11, 1); start_i = 1'b1;
    send(1); send(0); send(1);
    chk("t3_second_clean", inj_active_o, 0);
    send(0); send(1);
    chk("t3_third_corrupt", inj_active_o, 1);
    repeat (2) send(0);
    chk("t3_bit_err", bit_err_ct_o, 2);
    chk("t3_sym_ct", sym_ct_o, 3);
    chk("t3_done", done_o, 1);

    // 4: endless back-to-back bursts, aborted after 5 symbols
    set_cfg(0, 1, 2'b10, 0); start_i = 1'b1;
    repeat (5) send(1);
    abort_i = 1'b1; send(0);
    chk("t4_busy", busy_o, 0);
    chk("t4_done", done_o, 0);
    send(1);
    chk("t4_bit_err", bit_err_ct_o, 5);
    chk("t4_sym_ct", sym_ct_o, 5);
    chk("t4_idle_clean", inj_active_o, 0);

    // 5: asynchronous reset in the middle of a burst
    set_cfg(1, 5, 2'b11, 0); start_i = 1'b1;
    repeat (3) send(1);
    #3 rst = 1'b0;
    #1;
    chk("t5_rst_sym_o", sym_o, 0);
    chk("t5_rst_valid", sym_valid_o, 0);
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_sym_ct", sym_ct_o, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (5) send(1);
    chk("t5_clean_err", bit_err_ct_o, 0);
    chk("t5_idle", busy_o, 0);

    // 6: start+abort together is ignored; start during a run is ignored
    set_cfg(0, 1, 2'b11, 0); start_i = 1'b1; abort_i = 1'b1;
    send(1);
    chk("t6_abort_wins", busy_o, 0);
    set_cfg(3, 2, 2'b11, 1); start_i = 1'b1;
    send(1); send(1);
    set_cfg(0, 3, 2'b01, 2); start_i = 1'b1;
    repeat (5) send(1);
    chk("t6_bit_err", bit_err_ct_o, 4);
    chk("t6_sym_ct", sym_ct_o, 5);
    chk("t6_done", done_o, 1);
    start_i = 1'b1; abort_i = 1'b1; send(0);
    chk("t6_abort_done", done_o, 0);

    // L==0: bursts complete with their gaps, nothing is corrupted
    set_cfg(2, 0, 2'b11, 2); start_i = 1'b1;
    repeat (6) send(1);
    send(0);
    chk("l0_done", done_o, 1);
    chk("l0_sym_ct", sym_ct_o, 4);
    chk("l0_bit_err", bit_err_ct_o, 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
